// File: rtl/gfx256_pkg.sv
// Shared types and helpers for the gfx256 target reader.
//   LINE_BITS            width of one cache line / bus data beat
//   line_addr_t          32-byte line address (byte address bits [31:5])
//   gfx256_reader_state_e reader FSM states
//   sel_to_lane()        lowest set byte select -> 32-bit lane index
//   lane_word()          extract one 32-bit lane from a line
package gfx256_pkg;

  localparam int unsigned LINE_BITS = 256;

  typedef logic [31:5] line_addr_t;

  typedef enum logic [1:0] {
    StIdle,
    StBus,
    StDeliver
  } gfx256_reader_state_e;

  // Lane of the lowest set select bit; an all-zero select maps to lane 0.
  function automatic logic [2:0] sel_to_lane(input logic [31:0] sel);
    logic [2:0] lane;
    lane = 3'd0;
    // Walk downwards so the lowest set bit is the last one written.
    for (int i = 31; i >= 0; i--) begin
      if (sel[i]) lane = 3'(i / 4);
    end
    return lane;
  endfunction

  function automatic logic [31:0] lane_word(input logic [LINE_BITS-1:0] line,
                                            input logic [2:0]           lane);
    return line[{lane, 5'b0} +: 32];
  endfunction

endpackage

// File: rtl/gfx256_target_reader_if.sv
// Wishbone-style read bus between the target reader (master) and memory (slave).
//   cyc, stb  bus cycle / strobe
//   we        write enable (always 0 from the reader)
//   adr       byte address of the line
//   sel       byte selects
//   dat       full line returned by the slave
//   ack, err  slave completion / error
interface gfx256_target_reader_if;
  import gfx256_pkg::*;

  logic                 cyc;
  logic                 stb;
  logic                 we;
  logic [31:0]          adr;
  logic [31:0]          sel;
  logic [LINE_BITS-1:0] dat;
  logic                 ack;
  logic                 err;

  modport master (
    output cyc, stb, we, adr, sel,
    input  dat, ack, err
  );

  modport slave (
    input  cyc, stb, we, adr, sel,
    output dat, ack, err
  );

endinterface

// File: rtl/gfx256_rr_arb2.sv
// Two-way round-robin arbiter.
//   clk_i, rst_i  clock, asynchronous active-high reset
//   req           request vector, bit n = port n
//   advance       arbitration window open; a grant issued here moves the pointer
//   grant         one-hot grant, zero when advance is low or nothing requests
// After reset port 0 counts as last served, so port 1 wins the first tie.
module gfx256_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_q, last_d;  // index of the port granted most recently

  always_comb begin
    grant = 2'b00;
    if (advance) begin
      if (req == 2'b11) grant = last_q ? 2'b01 : 2'b10;
      else              grant = req;
    end
    last_d = last_q;
    if (|grant) last_d = grant[1];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) last_q <= 1'b0;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/gfx256_target_reader.sv
// Two-port read engine with a one-line cache in front of a 256-bit read bus.
//   clk_i, rst_i          clock, asynchronous active-high reset
//   c0_* (blender port)   req/addr/sel in, one-cycle ack and 32-bit data out
//   c1_* (texture port)   same as c0
//   busy_o                FSM is not idle
//   err_o, err_clr_i      sticky bus error / timeout flag and its clear
//   invalidate_i          drop the cached line
//   wbm                   bus master port (cyc/stb/adr/sel out, dat/ack/err in)
// Parameters: TIMEOUT bus cycles before abort, CACHE_EN enables hits.
module gfx256_target_reader
  import gfx256_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 255,
  parameter bit          CACHE_EN = 1'b1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          c0_req_i,
  input  logic [31:5]                   c0_addr_i,
  input  logic [31:0]                   c0_sel_i,
  output logic                          c0_ack_o,
  output logic [31:0]                   c0_data_o,
  input  logic                          c1_req_i,
  input  logic [31:5]                   c1_addr_i,
  input  logic [31:0]                   c1_sel_i,
  output logic                          c1_ack_o,
  output logic [31:0]                   c1_data_o,
  output logic                          busy_o,
  output logic                          err_o,
  input  logic                          err_clr_i,
  input  logic                          invalidate_i,
  gfx256_target_reader_if.master        wbm
);

  localparam logic [7:0] TmoLimit = 8'(TIMEOUT);

  gfx256_reader_state_e state_q, state_d;
  logic                 port_q, port_d;
  line_addr_t           addr_q, addr_d;
  logic [2:0]           lane_q, lane_d;
  logic [LINE_BITS-1:0] line_q, line_d;
  line_addr_t           line_addr_q, line_addr_d;
  logic                 valid_q, valid_d;
  logic                 inv_pend_q, inv_pend_d;  // invalidate seen while a fill is open
  logic                 err_q, err_d;
  logic [7:0]           tmo_q, tmo_d;
  logic [31:0]          data0_q, data0_d;
  logic [31:0]          data1_q, data1_d;

  logic [1:0]  grant;
  line_addr_t  req_addr;
  logic [2:0]  req_lane;
  logic        hit;
  logic        deliver;
  logic [31:0] deliver_word;

  gfx256_rr_arb2 u_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req     ({c1_req_i, c0_req_i}),
    .advance (state_q == StIdle),
    .grant   (grant)
  );

  assign req_addr = grant[1] ? c1_addr_i : c0_addr_i;
  assign req_lane = sel_to_lane(grant[1] ? c1_sel_i : c0_sel_i);
  // A same-cycle invalidate beats the hit so stale data is never returned.
  assign hit      = CACHE_EN && valid_q && (line_addr_q == req_addr) && !invalidate_i;

  always_comb begin
    state_d      = state_q;
    port_d       = port_q;
    addr_d       = addr_q;
    lane_d       = lane_q;
    line_d       = line_q;
    line_addr_d  = line_addr_q;
    valid_d      = valid_q;
    inv_pend_d   = inv_pend_q;
    tmo_d        = tmo_q;
    data0_d      = data0_q;
    data1_d      = data1_q;
    err_d        = err_q & ~err_clr_i;
    deliver      = 1'b0;
    deliver_word = '0;

    case (state_q)
      StIdle: begin
        if (invalidate_i) valid_d = 1'b0;
        if (|grant) begin
          port_d = grant[1];
          addr_d = req_addr;
          lane_d = req_lane;
          if (hit) begin
            state_d      = StDeliver;
            deliver      = 1'b1;
            deliver_word = lane_word(line_q, req_lane);
          end else begin
            state_d    = StBus;
            tmo_d      = '0;
            inv_pend_d = 1'b0;
          end
        end
      end

      StBus: begin
        if (invalidate_i) inv_pend_d = 1'b1;
        if (wbm.err || tmo_q == TmoLimit) begin
          // New error overrides a coincident err_clr_i.
          state_d = StDeliver;
          err_d   = 1'b1;
          valid_d = 1'b0;
          deliver = 1'b1;
        end else if (wbm.ack) begin
          state_d      = StDeliver;
          line_d       = wbm.dat;
          line_addr_d  = addr_q;
          valid_d      = ~(inv_pend_q | invalidate_i);
          deliver      = 1'b1;
          deliver_word = lane_word(wbm.dat, lane_q);
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end

      StDeliver: begin
        if (invalidate_i) valid_d = 1'b0;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase

    if (deliver) begin
      if (port_d) data1_d = deliver_word;
      else        data0_d = deliver_word;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      port_q      <= 1'b0;
      addr_q      <= '0;
      lane_q      <= '0;
      line_q      <= '0;
      line_addr_q <= '0;
      valid_q     <= 1'b0;
      inv_pend_q  <= 1'b0;
      err_q       <= 1'b0;
      tmo_q       <= '0;
      data0_q     <= '0;
      data1_q     <= '0;
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      addr_q      <= addr_d;
      lane_q      <= lane_d;
      line_q      <= line_d;
      line_addr_q <= line_addr_d;
      valid_q     <= valid_d;
      inv_pend_q  <= inv_pend_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
      data0_q     <= data0_d;
      data1_q     <= data1_d;
    end
  end

  // Bus strobes decode straight from the state register so reset drops them at once.
  assign wbm.cyc = (state_q == StBus);
  assign wbm.stb = (state_q == StBus);
  assign wbm.we  = 1'b0;
  assign wbm.adr = {addr_q, 5'b0};
  assign wbm.sel = '1;

  assign c0_ack_o  = (state_q == StDeliver) && !port_q;
  assign c1_ack_o  = (state_q == StDeliver) && port_q;
  assign c0_data_o = data0_q;
  assign c1_data_o = data1_q;
  assign busy_o    = (state_q != StIdle);
  assign err_o     = err_q;

endmodule

// File: tb/tb_gfx256_target_reader.sv
// Scoreboard bench for gfx256_target_reader: stimulus pushes expected responses,
// a monitor pops and compares them on every ack.
module tb_gfx256_target_reader;
  import gfx256_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        c0_req_i = 1'b0, c1_req_i = 1'b0;
  line_addr_t  c0_addr_i = '0, c1_addr_i = '0;
  logic [31:0] c0_sel_i = '0, c1_sel_i = '0;
  logic        c0_ack_o, c1_ack_o;
  logic [31:0] c0_data_o, c1_data_o;
  logic        busy_o, err_o;
  logic        err_clr_i = 1'b0, invalidate_i = 1'b0;

  always #5 clk_i = ~clk_i;

  gfx256_target_reader_if wbm ();

  gfx256_target_reader #(
    .TIMEOUT  (4),
    .CACHE_EN (1'b1)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .c0_req_i     (c0_req_i),
    .c0_addr_i    (c0_addr_i),
    .c0_sel_i     (c0_sel_i),
    .c0_ack_o     (c0_ack_o),
    .c0_data_o    (c0_data_o),
    .c1_req_i     (c1_req_i),
    .c1_addr_i    (c1_addr_i),
    .c1_sel_i     (c1_sel_i),
    .c1_ack_o     (c1_ack_o),
    .c1_data_o    (c1_data_o),
    .busy_o       (busy_o),
    .err_o        (err_o),
    .err_clr_i    (err_clr_i),
    .invalidate_i (invalidate_i),
    .wbm          (wbm)
  );

  // Slave model: mode 0 acks, 1 errors, 2 never answers; answers after slv_wait cycles.
  logic [LINE_BITS-1:0] slv_line = '0;
  int                   slv_mode = 0;
  int                   slv_wait = 3;
  int                   slv_cnt  = 0;
  int                   bus_cycles = 0;
  logic [31:0]          last_adr = '0;

  assign wbm.dat = slv_line;

  always @(negedge clk_i) begin
    if (wbm.cyc && wbm.stb) begin
      wbm.ack    = (slv_mode == 0) && (slv_cnt == slv_wait);
      wbm.err    = (slv_mode == 1) && (slv_cnt == slv_wait);
      slv_cnt    = slv_cnt + 1;
      bus_cycles = bus_cycles + 1;
      last_adr   = wbm.adr;
    end else begin
      wbm.ack = 1'b0;
      wbm.err = 1'b0;
      slv_cnt = 0;
    end
  end

  typedef struct packed {
    logic        port;
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mon_data;

  // Monitor: every ack must match the oldest expected response.
  always @(negedge clk_i) begin
    if (c0_ack_o || c1_ack_o) begin
      checks = checks + 1;
      mon_data = c1_ack_o ? c1_data_o : c0_data_o;
      if (c0_ack_o && c1_ack_o) begin
        errors = errors + 1;
        $display("FAIL ack_overlap: c0_ack=1 c1_ack=1, required one ack at a time");
      end else if (sb_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_ack: port %0d data %h, required no ack", c1_ack_o, mon_data);
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_e.port !== c1_ack_o || mon_e.data !== mon_data) begin
          errors = errors + 1;
          $display("FAIL response: got port %0d data %h, required port %0d data %h",
                   c1_ack_o, mon_data, mon_e.port, mon_e.data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic drive_req(input bit p, input bit on, input line_addr_t a, input logic [31:0] s);
    if (p) begin c1_addr_i = a; c1_sel_i = s; c1_req_i = on; end
    else   begin c0_addr_i = a; c0_sel_i = s; c0_req_i = on; end
  endtask

  task automatic wait_ack(input bit p, output bit got, output int lat);
    got = 1'b0;
    lat = -1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk_i);
      if (p ? c1_ack_o : c0_ack_o) begin
        got = 1'b1;
        lat = i;
      end
    end
  endtask

  // One read: expected data goes to the scoreboard; latency (negedges from the
  // drive point to the ack) and bus cycles are checked here.
  task automatic do_read(input bit p, input line_addr_t a, input logic [31:0] s,
                         input logic [31:0] exp_data, input int exp_lat, input int exp_bus,
                         input string name);
    bit got;
    int lat;
    int b0;
    @(posedge clk_i);
    #1;
    sb_q.push_back(exp_t'{port: p, data: exp_data});
    b0 = bus_cycles;
    drive_req(p, 1'b1, a, s);
    wait_ack(p, got, lat);
    if (!got && sb_q.size() > 0) void'(sb_q.pop_back());
    check({name, "_latency"}, lat, exp_lat);
    @(posedge clk_i);
    #1;
    drive_req(p, 1'b0, a, s);
    check({name, "_bus_cycles"}, bus_cycles - b0, exp_bus);
  endtask

  task automatic pulse(input bit inv, input bit clr);
    @(posedge clk_i);
    #1;
    invalidate_i = inv;
    err_clr_i    = clr;
    @(posedge clk_i);
    #1;
    invalidate_i = 1'b0;
    err_clr_i    = 1'b0;
  endtask

  localparam logic [LINE_BITS-1:0] Line1 = {32'h7777_7777, 32'h6666_6666, 32'hCAFE_F00D,
                                            32'h4444_4444, 32'hDEAD_BEEF, 32'h2222_2222,
                                            32'h1111_1111, 32'h1000_0000};
  localparam logic [LINE_BITS-1:0] Line2 = {32'hA000_0007, 32'hA000_0006, 32'hA000_0005,
                                            32'hA000_0004, 32'hA000_0003, 32'hA000_0002,
                                            32'hA000_0001, 32'hA000_0000};
  localparam logic [LINE_BITS-1:0] Line3 = {32'hB000_0007, 32'hB000_0006, 32'hB000_0005,
                                            32'hB000_0004, 32'hB000_0003, 32'hB000_0002,
                                            32'hB000_0001, 32'hB000_0000};

  initial begin
    bit got;
    bit seen;
    int lat;
    int b0;
    int acks;

    #3;
    check("reset_busy", busy_o, 0);
    check("reset_err", err_o, 0);
    check("reset_cyc", wbm.cyc, 0);
    check("reset_stb", wbm.stb, 0);
    check("reset_acks", {c1_ack_o, c0_ack_o}, 0);
    check("reset_c0_data", c0_data_o, 0);
    check("reset_c1_data", c1_data_o, 0);
    check("bus_we", wbm.we, 0);
    check("bus_sel", wbm.sel, 32'hFFFF_FFFF);
    #19 rst_i = 1'b0;

    // Contention straight after reset: port 1 first (miss), then port 0 (hit).
    slv_line = Line1;
    @(posedge clk_i);
    #1;
    sb_q.push_back(exp_t'{port: 1'b1, data: 32'hCAFE_F00D});
    sb_q.push_back(exp_t'{port: 1'b0, data: 32'hDEAD_BEEF});
    b0 = bus_cycles;
    drive_req(1'b1, 1'b1, 27'h10, 32'h00F0_0000);
    drive_req(1'b0, 1'b1, 27'h10, 32'h0000_F000);
    wait_ack(1'b1, got, lat);
    check("contend_c1_latency", lat, 5);
    @(posedge clk_i);
    #1;
    c1_req_i = 1'b0;
    wait_ack(1'b0, got, lat);
    check("contend_c0_latency", lat, 1);
    @(posedge clk_i);
    #1;
    c0_req_i = 1'b0;
    check("contend_bus_cycles", bus_cycles - b0, 4);

    do_read(1'b0, 27'h2, 32'h0000_F000, 32'hDEAD_BEEF, 5, 4, "single_miss");
    check("miss_adr", last_adr, 32'h0000_0040);
    do_read(1'b0, 27'h2, 32'h00F0_0000, 32'hCAFE_F00D, 1, 0, "hit_lane5");
    do_read(1'b0, 27'h2, 32'h0000_0000, 32'h1000_0000, 1, 0, "hit_sel0");
    do_read(1'b1, 27'h2, 32'h8000_0000, 32'h7777_7777, 1, 0, "hit_lane7");
    do_read(1'b0, 27'h2, 32'h0000_0110, 32'h1111_1111, 1, 0, "hit_multi_sel");

    pulse(1'b1, 1'b0);
    do_read(1'b0, 27'h2, 32'h0000_F000, 32'hDEAD_BEEF, 5, 4, "after_idle_inv");

    // Invalidate mid-fill: data still delivered, but the line must not be kept.
    slv_line = Line2;
    fork
      do_read(1'b0, 27'h3, 32'h0000_000F, 32'hA000_0000, 5, 4, "inv_bus_fill");
      begin
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
          @(negedge clk_i);
          seen = wbm.cyc;
        end
        pulse(1'b1, 1'b0);
      end
    join
    slv_line = Line3;
    do_read(1'b0, 27'h3, 32'h0000_000F, 32'hB000_0000, 5, 4, "inv_bus_refetch");

    // Bus error: zero data, sticky err_o, cached line dropped.
    slv_mode = 1;
    slv_wait = 0;
    do_read(1'b0, 27'h4, 32'h0000_0F00, 32'h0000_0000, 2, 1, "bus_err");
    check("err_set", err_o, 1);
    slv_mode = 0;
    slv_wait = 3;
    do_read(1'b0, 27'h3, 32'h0000_000F, 32'hB000_0000, 5, 4, "err_drops_line");
    check("err_sticky", err_o, 1);
    pulse(1'b0, 1'b1);
    check("err_clear", err_o, 0);

    // Timeout with TIMEOUT=4: five bus cycles then abort.
    slv_mode = 2;
    do_read(1'b1, 27'h5, 32'h000F_0000, 32'h0000_0000, 6, 5, "timeout");
    check("timeout_err", err_o, 1);
    pulse(1'b0, 1'b1);
    check("timeout_clear", err_o, 0);

    // Reset during a fill: strobes drop immediately, no ack, cache emptied.
    slv_mode = 0;
    slv_line = Line1;
    do_read(1'b0, 27'h2, 32'h0000_F000, 32'hDEAD_BEEF, 5, 4, "refill");
    do_read(1'b0, 27'h2, 32'h00F0_0000, 32'hCAFE_F00D, 1, 0, "refill_hit");
    @(posedge clk_i);
    #1;
    drive_req(1'b0, 1'b1, 27'h6, 32'h0000_F000);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk_i);
      seen = wbm.cyc;
    end
    check("rst_mid_bus_reached", seen, 1);
    #2 rst_i = 1'b1;
    #1;
    check("rst_mid_cyc", wbm.cyc, 0);
    check("rst_mid_stb", wbm.stb, 0);
    check("rst_mid_busy", busy_o, 0);
    check("rst_mid_c0_data", c0_data_o, 0);
    c0_req_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      acks = acks + int'(c0_ack_o) + int'(c1_ack_o);
    end
    check("rst_mid_no_ack", acks, 0);
    do_read(1'b0, 27'h2, 32'h0000_F000, 32'hDEAD_BEEF, 5, 4, "post_rst_miss");

    repeat (3) @(posedge clk_i);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/gfx256_target_reader.md
GFX256_TARGET_READER -- requirements
Module: gfx256_target_reader

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the bus cycles waited for wbm_ack_i/wbm_err_i before the read is aborted.
REQ-002 SHALL have parameter CACHE_EN, default 1, meaning the one-line read cache is enabled; 0 forces every request onto the bus.
REQ-003 clk_i  in  1  clock; rst_i  in  1  reset, asynchronous, active-high.
REQ-004 c0_req_i  in  1  read request from the blender target port (port 0); c0_addr_i  in  [31:5]  line address; c0_sel_i  in  32  byte selects; c0_ack_o  out  1  one-cycle completion strobe; c0_data_o  out  32  read word.
REQ-005 c1_req_i, c1_addr_i, c1_sel_i, c1_ack_o, c1_data_o: the same widths and meanings for the texture port (port 1).
REQ-006 busy_o  out  1  high whenever the state is not IDLE.
REQ-007 err_o  out  1  sticky high after a bus error or timeout; cleared by err_clr_i  in  1.
REQ-008 invalidate_i  in  1  discards the cached line.
REQ-009 wbm_cyc_o  out  1; wbm_stb_o  out  1; wbm_we_o  out  1 (tied 0); wbm_adr_o  out  32 = {line address, 5'b0}; wbm_sel_o  out  32 (all ones); wbm_dat_i  in  256; wbm_ack_i  in  1; wbm_err_i  in  1.

Function
REQ-010 The state machine SHALL have states IDLE, BUS and DELIVER; transitions are IDLE->DELIVER (cache hit), IDLE->BUS (miss), BUS->DELIVER (ack, err or timeout), DELIVER->IDLE (always, after one cycle).
REQ-011 In IDLE, arbitration SHALL be round-robin: when both requests are high, the port not granted last wins; the pointer updates on every grant.
REQ-012 The grant, address and selects SHALL be registered on the IDLE edge; the requester's later input changes are ignored until DELIVER.
REQ-013 Lane SHALL be the index of the lowest set c*_sel_i bit divided by 4 (0..7); sel==0 selects lane 0.
REQ-014 A hit SHALL require CACHE_EN, cache valid, and cached address == requested address; latency is ack one cycle after the IDLE sampling edge.
REQ-015 On a miss, BUS SHALL assert cyc/stb with the registered address until wbm_ack_i, wbm_err_i or timeout; cyc/stb drop on the edge that leaves BUS.
REQ-016 On wbm_ack_i, the reader SHALL latch wbm_dat_i into the cache line and its address, set valid, and deliver the lane word.
REQ-017 On wbm_err_i or timeout counter == TIMEOUT, the reader SHALL deliver data 32'h0, set err_o and clear valid.
REQ-018 In DELIVER, only the granted port's ack SHALL be high, for exactly one cycle, with data_o = line[lane*32 +: 32].
REQ-019 The ungranted ack SHALL stay 0; data outputs hold their value outside DELIVER.
REQ-020 A request still high in the cycle after its ack SHALL NOT be re-served, because DELIVER->IDLE consumes that cycle; the client drops the request on the ack edge.
REQ-021 invalidate_i in IDLE or DELIVER SHALL clear valid next edge.
REQ-022 invalidate_i during BUS SHALL set a pending flag so the completing fill still delivers data but leaves valid=0.
REQ-023 invalidate_i coincident with a hit check in IDLE SHALL force a miss.
REQ-024 When err_clr_i and a new error coincide, the error SHALL win.
REQ-025 The timeout counter SHALL be 8 bits, cleared on BUS entry, and SHALL increment each BUS cycle without ack/err.

Reset
REQ-026 On rst_i: state=IDLE; all acks, cyc, stb, err_o and busy_o = 0; data outputs = 0; cache valid = 0; round-robin pointer = port 0 last (port 1 favoured first); timeout counter = 0.
REQ-027 Reset asserted mid-BUS SHALL drop cyc/stb immediately (asynchronously) with no ack issued.

Structure
REQ-028 The state enum gfx256_reader_state_e and the constant LINE_BITS=256 SHALL live in gfx256_pkg.
REQ-029 The round-robin arbiter SHALL be the one natural sub-module, gfx256_rr_arb2 (req[1:0], ack-advance in, grant out).

Verification
REQ-030 Single miss: c0 requests 0x0000_0040>>5, sel=32'h0000_F000 (lane 3); slave acks after 3 cycles with dat lane3=32'hDEADBEEF -> c0_ack_o one cycle, c0_data_o=DEADBEEF, cyc high exactly 4 cycles.
REQ-031 Hit: repeat the same address with sel lane 5 -> ack one cycle after sampling, no cyc, data = lane-5 word.
REQ-032 Contention: c0 and c1 high together after reset -> c1 served first, then c0; acks never overlap.
REQ-033 Invalidate during BUS: assert invalidate_i mid-fill -> data delivered, next same-address request goes to the bus.
REQ-034 Error/timeout: wbm_err_i -> data 0, err_o=1. With no slave ack and TIMEOUT=4 -> abort after 5 BUS cycles, err_o=1; err_clr_i clears it.
REQ-035 Reset mid-BUS: rst_i pulse -> cyc/stb low same cycle, no ack, valid=0.
